// File: rtl/traffic_seg_scan_sched.sv
// -----------------------------------------------------------------------------
// traffic_seg_scan_sched
//
// Display scheduler for the traffic-light countdowns. One 4-digit multiplexed
// 7-segment display is shared between the east-west (EW) and south-north (SN)
// remaining-time values. Each 6-bit time is converted to two BCD digits by a
// repeated-subtraction converter; all four digits are committed together so
// the display never shows a half-updated pair. The display blinks during the
// yellow phases (state 1 and 3).
//
// Ports:
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   state      in   2  light phase (0/2 steady, 1/3 yellow -> blink)
//   ew_time    in   6  EW remaining seconds, 0..63
//   sn_time    in   6  SN remaining seconds, 0..63
//   seg_sel    out  4  digit select, one-hot active-low, bit3 = leftmost digit
//   seg_led    out  8  segments {dp,g,f,e,d,c,b,a}, active-low
//   conv_busy  out  1  high while a BCD conversion is in progress
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is blanked for the
//                          whole slot; otherwise it is shown as "0".
// -----------------------------------------------------------------------------
module traffic_seg_scan_sched #(
  parameter int SCAN_CNT  = 50_000,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_CNT = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] state,
  input  logic [5:0] ew_time,
  input  logic [5:0] sn_time,
  output logic [3:0] seg_sel,
  output logic [7:0] seg_led,
  output logic       conv_busy
);

  localparam int SCAN_W  = (SCAN_CNT  > 1) ? $clog2(SCAN_CNT)  : 1;
  localparam int BLINK_W = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CNT - 1);
  localparam logic [SCAN_W-1:0]  BLANK_LIM  = SCAN_W'(BLANK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV_EW = 2'd1,
    CONV_SN = 2'd2,
    COMMIT  = 2'd3
  } conv_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers: {state, ew_time, sn_time} are quasi-static, so a
  // plain 2-flop bundle is enough; only the second-stage copies are used.
  // ---------------------------------------------------------------------------
  logic [13:0] sync1_reg;
  logic [13:0] sync2_reg;
  logic [1:0]  state_sync;
  logic [5:0]  ew_sync;
  logic [5:0]  sn_sync;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {state, ew_time, sn_time};
      sync2_reg <= sync1_reg;
    end
  end

  assign state_sync = sync2_reg[13:12];
  assign ew_sync    = sync2_reg[11:6];
  assign sn_sync    = sync2_reg[5:0];

  // ---------------------------------------------------------------------------
  // Conversion FSM. Snapshots are taken in IDLE so that input changes during
  // a conversion are simply caught by the next IDLE comparison.
  // ---------------------------------------------------------------------------
  conv_state_t conv_state_reg;
  logic        dirty_reg;
  logic [5:0]  ew_snap_reg;
  logic [5:0]  sn_snap_reg;
  logic [5:0]  rem_reg;
  logic [3:0]  tens_reg;
  logic [3:0]  ew_tens_tmp_reg;
  logic [3:0]  ew_ones_tmp_reg;
  logic [3:0]  ew_tens_reg;
  logic [3:0]  ew_ones_reg;
  logic [3:0]  sn_tens_reg;
  logic [3:0]  sn_ones_reg;
  logic        conv_busy_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      conv_state_reg  <= IDLE;
      dirty_reg       <= 1'b1;
      ew_snap_reg     <= '0;
      sn_snap_reg     <= '0;
      rem_reg         <= '0;
      tens_reg        <= '0;
      ew_tens_tmp_reg <= '0;
      ew_ones_tmp_reg <= '0;
      ew_tens_reg     <= '0;
      ew_ones_reg     <= '0;
      sn_tens_reg     <= '0;
      sn_ones_reg     <= '0;
      conv_busy_reg   <= 1'b0;
    end else begin
      case (conv_state_reg)
        IDLE: begin
          if (dirty_reg || (ew_sync != ew_snap_reg) || (sn_sync != sn_snap_reg)) begin
            ew_snap_reg    <= ew_sync;
            sn_snap_reg    <= sn_sync;
            dirty_reg      <= 1'b0;
            rem_reg        <= ew_sync;
            tens_reg       <= '0;
            conv_busy_reg  <= 1'b1;
            conv_state_reg <= CONV_EW;
          end
        end
        CONV_EW: begin
          if (rem_reg >= 6'd10) begin
            rem_reg  <= rem_reg - 6'd10;
            tens_reg <= tens_reg + 4'd1;
          end else begin
            ew_tens_tmp_reg <= tens_reg;
            ew_ones_tmp_reg <= rem_reg[3:0];
            rem_reg         <= sn_snap_reg;
            tens_reg        <= '0;
            conv_state_reg  <= CONV_SN;
          end
        end
        CONV_SN: begin
          if (rem_reg >= 6'd10) begin
            rem_reg  <= rem_reg - 6'd10;
            tens_reg <= tens_reg + 4'd1;
          end else begin
            // SN result lands directly in the committed digits at COMMIT,
            // so hold it in rem/tens for one more cycle.
            conv_state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          // All four digits change in the same cycle.
          ew_tens_reg    <= ew_tens_tmp_reg;
          ew_ones_reg    <= ew_ones_tmp_reg;
          sn_tens_reg    <= tens_reg;
          sn_ones_reg    <= rem_reg[3:0];
          conv_busy_reg  <= 1'b0;
          conv_state_reg <= IDLE;
        end
        default: conv_state_reg <= IDLE;
      endcase
    end
  end

  assign conv_busy = conv_busy_reg;

  // ---------------------------------------------------------------------------
  // Scan timing: slot counter and digit index.
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] slot_cnt_reg;
  logic [1:0]        digit_idx_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= '0;
    end else if (slot_cnt_reg == SCAN_LAST) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= digit_idx_reg + 2'd1;
    end else begin
      slot_cnt_reg  <= slot_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink: only runs in yellow (state bit0 set); any state change restarts
  // the half-period with the display ON.
  // ---------------------------------------------------------------------------
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_on_reg;
  logic [1:0]         state_prev_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt_reg  <= '0;
      blink_on_reg   <= 1'b1;
      state_prev_reg <= '0;
    end else begin
      state_prev_reg <= state_sync;
      if (state_sync != state_prev_reg) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
      end else if (state_sync[0]) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end else begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Segment path
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  logic [3:0] cur_digit;
  logic [3:0] sel_next;
  logic [7:0] led_next;
  logic       lead_zero_blank;

  always_comb begin
    cur_digit = '0;
    case (digit_idx_reg)
      2'd0:    cur_digit = ew_tens_reg;
      2'd1:    cur_digit = ew_ones_reg;
      2'd2:    cur_digit = sn_tens_reg;
      default: cur_digit = sn_ones_reg;
    endcase
  end

  // idx0 drives the leftmost digit (bit3), idx3 the rightmost (bit0).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sel
      assign sel_next[gi] = (digit_idx_reg != 2'(3 - gi));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Even indices are the tens digits.
  assign lead_zero_blank = ~digit_idx_reg[0] && (cur_digit == 4'd0);
`else
  assign lead_zero_blank = 1'b0;
`endif

  always_comb begin
    led_next = seg_decode(cur_digit);
    if ((slot_cnt_reg < BLANK_LIM) || !blink_on_reg || lead_zero_blank) begin
      led_next = 8'hFF;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_sel <= 4'b1111;
      seg_led <= 8'hFF;
    end else begin
      seg_sel <= sel_next;
      seg_led <= led_next;
    end
  end

endmodule

// File: tb/tb_traffic_seg_scan_sched.sv
// -----------------------------------------------------------------------------
// tb_traffic_seg_scan_sched
//
// Directed bench for traffic_seg_scan_sched with SCAN_CNT=4, BLANK_CYC=1,
// BLINK_CNT=16. Expected segment codes and timings are hand-computed.
// -----------------------------------------------------------------------------
module tb_traffic_seg_scan_sched;

  localparam int SCAN_CNT  = 4;
  localparam int BLANK_CYC = 1;
  localparam int BLINK_CNT = 16;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] TENS_ZERO = 8'hFF;
`else
  localparam logic [7:0] TENS_ZERO = 8'hC0;
`endif

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] state     = 2'd0;
  logic [5:0] ew_time   = 6'd0;
  logic [5:0] sn_time   = 6'd0;
  logic [3:0] seg_sel;
  logic [7:0] seg_led;
  logic       conv_busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  traffic_seg_scan_sched #(
    .SCAN_CNT (SCAN_CNT),
    .BLANK_CYC(BLANK_CYC),
    .BLINK_CNT(BLINK_CNT)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .state    (state),
    .ew_time  (ew_time),
    .sn_time  (sn_time),
    .seg_sel  (seg_sel),
    .seg_led  (seg_led),
    .conv_busy(conv_busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Align to the start of the leftmost-digit slot, then check one full frame
  // cycle by cycle: blank cycle first, then the decoded digit.
  task automatic check_frame(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] code [4];
    logic [3:0] pat  [4];
    logic [3:0] prev;
    int         n;
    bit         found;
    int         err_before;
    code[0] = c0; code[1] = c1; code[2] = c2; code[3] = c3;
    pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
    err_before = err_cnt;
    prev  = seg_sel;
    found = 1'b0;
    n     = 0;
    while (!found && n < 40) begin
      @(negedge sys_clk);
      n++;
      if (seg_sel == 4'b0111 && prev != 4'b0111) found = 1'b1;
      else prev = seg_sel;
    end
    check_value({tag, "_align"}, 32'(found), 32'd1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge sys_clk);
        check_value($sformatf("%s_sel%0d", tag, i), 32'(seg_sel), 32'(pat[i/4]));
        check_value($sformatf("%s_led%0d", tag, i), 32'(seg_led),
                    (i % 4 == 0) ? 32'hFF : 32'(code[i/4]));
      end
    end
    $display("frame %s: expected %h %h %h %h, errors in frame %0d",
             tag, c0, c1, c2, c3, err_cnt - err_before);
  endtask

  // Wait (bounded) for conv_busy to rise and count its high samples.
  task automatic busy_pulse(output int len);
    int w;
    w   = 0;
    len = 0;
    while (!conv_busy && w < 30) begin
      @(negedge sys_clk);
      w++;
    end
    while (conv_busy && len < 40) begin
      len++;
      @(negedge sys_clk);
    end
  endtask

  logic [7:0] led_s [72];
  logic [3:0] sel_s [72];

  initial begin
    int  len;
    int  gap;
    int  cnt;
    bit  seen;

    // ---- reset values ------------------------------------------------------
    ew_time = 6'd29;
    sn_time = 6'd26;
    state   = 2'd0;
    repeat (3) @(negedge sys_clk);
    check_value("rst_sel",  32'(seg_sel),   32'hF);
    check_value("rst_led",  32'(seg_led),   32'hFF);
    check_value("rst_busy", 32'(conv_busy), 32'd0);
    $display("reset: sel=%b led=%h busy=%b", seg_sel, seg_led, conv_busy);

    // ---- first conversion after release -------------------------------------
    sys_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (conv_busy) seen = 1'b1;
    end
    check_value("busy_after_rst", 32'(seen), 32'd1);
    repeat (40) @(negedge sys_clk);
    check_frame("ew29_sn26", 8'hA4, 8'h90, 8'hA4, 8'h82);

    // ---- 63 / 0: seven-step EW subtraction ----------------------------------
    ew_time = 6'd63;
    sn_time = 6'd0;
    busy_pulse(len);
    check_value("busy_len_63_0", 32'(len), 32'd9);
    $display("conv 63/0: busy cycles %0d", len);
    check_frame("ew63_sn0", 8'h82, 8'hB0, TENS_ZERO, 8'hC0);

    // ---- change during CONV_EW ----------------------------------------------
    ew_time = 6'd29;
    sn_time = 6'd26;
    cnt = 0;
    while (!conv_busy && cnt < 30) begin
      @(negedge sys_clk);
      cnt++;
    end
    len = 0;
    while (conv_busy && len < 40) begin
      len++;
      if (len == 3) ew_time = 6'd28;
      @(negedge sys_clk);
    end
    check_value("busy_len_29", 32'(len), 32'd7);
    gap = 0;
    while (!conv_busy && gap < 10) begin
      gap++;
      @(negedge sys_clk);
    end
    check_value("restart_gap", 32'(gap), 32'd1);
    busy_pulse(len);
    check_value("busy_len_28", 32'(len), 32'd7);
    $display("mid-conversion change: gap %0d second busy %0d", gap, len);
    check_frame("ew28_sn26", 8'hA4, 8'h80, 8'hA4, 8'h82);

    // ---- blink in yellow ----------------------------------------------------
    state = 2'd1;
    for (int k = 1; k <= 57; k++) begin
      @(negedge sys_clk);
      led_s[k] = seg_led;
      sel_s[k] = seg_sel;
    end
    cnt = 0;
    for (int k = 4; k <= 19; k++) if (led_s[k] != 8'hFF) cnt++;
    check_value("blink_on1_vis", 32'(cnt), 32'd12);
    cnt = 0;
    for (int k = 20; k <= 35; k++) if (led_s[k] == 8'hFF) cnt++;
    check_value("blink_off_ff", 32'(cnt), 32'd16);
    cnt = 0;
    for (int k = 20; k <= 35; k++) if (sel_s[k] != sel_s[k-1]) cnt++;
    check_value("blink_off_scan", 32'(cnt), 32'd4);
    cnt = 0;
    for (int k = 36; k <= 51; k++) if (led_s[k] != 8'hFF) cnt++;
    check_value("blink_on2_vis", 32'(cnt), 32'd12);
    cnt = 0;
    for (int k = 52; k <= 57; k++) if (led_s[k] == 8'hFF) cnt++;
    check_value("blink_off2_ff", 32'(cnt), 32'd6);
    $display("blink: phases checked over 57 cycles");

    // ---- leave yellow during OFF phase --------------------------------------
    state = 2'd2;
    for (int k = 1; k <= 7; k++) begin
      @(negedge sys_clk);
      led_s[k] = seg_led;
    end
    check_value("green_r2_off", 32'(led_s[2]), 32'hFF);
    cnt = 0;
    for (int k = 4; k <= 7; k++) if (led_s[k] != 8'hFF) cnt++;
    check_value("green_on_vis", 32'(cnt), 32'd3);
    $display("state 2: display on, visible %0d of 4", cnt);

    // ---- reset during CONV_SN -----------------------------------------------
    ew_time = 6'd63;
    sn_time = 6'd5;
    cnt = 0;
    while (!conv_busy && cnt < 30) begin
      @(negedge sys_clk);
      cnt++;
    end
    repeat (7) @(negedge sys_clk);
    check_value("in_conv_sn_busy", 32'(conv_busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check_value("async_rst_sel",  32'(seg_sel),   32'hF);
    check_value("async_rst_led",  32'(seg_led),   32'hFF);
    check_value("async_rst_busy", 32'(conv_busy), 32'd0);
    $display("async reset during CONV_SN: sel=%b led=%h", seg_sel, seg_led);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (50) @(negedge sys_clk);
    check_frame("ew63_sn5", 8'h82, 8'hB0, TENS_ZERO, 8'h92);

    // ---- 10 / 9 -------------------------------------------------------------
    ew_time = 6'd10;
    sn_time = 6'd9;
    busy_pulse(len);
    check_value("busy_len_10_9", 32'(len), 32'd4);
    $display("conv 10/9: busy cycles %0d", len);
    check_frame("ew10_sn9", 8'hF9, 8'hC0, TENS_ZERO, 8'h90);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
